// File: rtl/serial_bus_loader_pkg.sv
// Shared constants for the serial bus loader and its bench.
//   - command bytes recognised in IDLE ('L' starts a load, 'G' releases the CPU)
//   - command FSM state encodings
//   - default UART bit period (27 MHz / 4 system clock at 28800 baud)
package serial_bus_loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 234;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_LEN     = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_WRITE   = 3'd5;
  localparam logic [2:0] ST_CSUM    = 3'd6;

endpackage

// File: rtl/serial_bus_loader_if.sv
// Bus-side signals of the serial bus loader.
//   address   bus address while the loader owns the bus (bits 18:16 always 0)
//   write_en  one-clock write strobe per loaded byte
//   data_out  write data
//   cpu_hold  high while the loader owns the bus / CPU is held
//   load_ok   last load ended with a matching checksum
//   load_err  last load ended with a checksum mismatch or framing error
// master: the loader (drives everything); slave: the consumer (top-level mux).
interface serial_bus_loader_if;
  logic [18:0] address;
  logic        write_en;
  logic [7:0]  data_out;
  logic        cpu_hold;
  logic        load_ok;
  logic        load_err;

  modport master (
    output address, write_en, data_out, cpu_hold, load_ok, load_err
  );

  modport slave (
    input address, write_en, data_out, cpu_hold, load_ok, load_err
  );
endinterface

// File: rtl/serial_bus_loader_uart_rx.sv
// 8N1 UART receiver.
//   clock, reset  system clock, synchronous active-high reset
//   rx            asynchronous serial line, idle high
//   byte_valid    one-clock pulse when a byte with a good stop bit arrives
//   frame_err     one-clock pulse instead of byte_valid when the stop bit is low
//   data_byte     received byte, valid while byte_valid is high
module uart_rx
  import serial_bus_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] data_byte
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign data_byte = shift;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          // Mid-start-bit check: a line that is high again was a glitch.
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};  // LSB first
            if (bit_idx == 3'd7) state <= RX_STOP;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin  // RX_STOP
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_bus_loader.sv
// Serial bus loader: receives 'L' <addr_hi> <addr_lo> <len> <data...> <csum>
// over a UART and writes the data bytes to consecutive bus addresses while
// holding the CPU. 'G' in IDLE releases the CPU.
//   clock, reset  system clock, synchronous active-high reset
//   rx            UART receive line (8N1, idle high, asynchronous)
//   bus           loader bus outputs (master side of serial_bus_loader_if)
module serial_bus_loader
  import serial_bus_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit RESET_HOLD   = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  serial_bus_loader_if.master bus
);

  logic       byte_valid, frame_err;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .data_byte  (rx_byte)
  );

  logic [2:0]  state;
  logic [15:0] addr;
  logic [7:0]  data_reg;
  logic [7:0]  count;
  logic [7:0]  sum;
  logic        hold, ok, err;
  logic [7:0]  csum_total;

  assign csum_total   = sum + rx_byte;

  assign bus.address  = {3'b000, addr};
  assign bus.write_en = (state == ST_WRITE);
  assign bus.data_out = data_reg;
  assign bus.cpu_hold = hold;
  assign bus.load_ok  = ok;
  assign bus.load_err = err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr     <= '0;
      data_reg <= '0;
      count    <= '0;
      sum      <= '0;
      hold     <= RESET_HOLD;
      ok       <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (byte_valid) begin
            if (rx_byte == CMD_LOAD) begin
              state <= ST_ADDR_HI;
              hold  <= 1'b1;
              ok    <= 1'b0;
              err   <= 1'b0;
              sum   <= '0;
            end else if (rx_byte == CMD_GO) begin
              hold <= 1'b0;
            end
          end
        end
        ST_ADDR_HI: if (byte_valid) begin
          addr[15:8] <= rx_byte;
          state      <= ST_ADDR_LO;
        end
        ST_ADDR_LO: if (byte_valid) begin
          addr[7:0] <= rx_byte;
          state     <= ST_LEN;
        end
        ST_LEN: if (byte_valid) begin
          // 0 wraps to 255 after the first write, so it yields 256 bytes.
          count <= rx_byte;
          state <= ST_DATA;
        end
        ST_DATA: if (byte_valid) begin
          data_reg <= rx_byte;
          sum      <= sum + rx_byte;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          addr  <= addr + 16'd1;
          count <= count - 8'd1;
          state <= (count == 8'd1) ? ST_CSUM : ST_DATA;
        end
        ST_CSUM: if (byte_valid) begin
          ok    <= (csum_total == 8'h00);
          err   <= (csum_total != 8'h00);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A broken frame aborts any load in progress; the CPU stays held.
      if (frame_err && state != ST_IDLE) begin
        err   <= 1'b1;
        ok    <= 1'b0;
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serial_bus_loader.sv
module tb_serial_bus_loader;
  import serial_bus_loader_pkg::*;

  localparam int CPB = 8;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  int checks = 0;
  int errors = 0;

  serial_bus_loader_if bus_if ();

  serial_bus_loader #(.CLKS_PER_BIT(CPB), .RESET_HOLD(1'b1)) dut (
    .clock (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every write and checks strobe width and latency.
  logic [26:0] wq[$];
  logic we_prev = 1'b0;
  logic bv_prev = 1'b0;

  always @(negedge clk) begin
    if (bus_if.write_en) begin
      wq.push_back({bus_if.address, bus_if.data_out});
      checks++;
      if (we_prev) begin
        errors++;
        $display("FAIL write_en_width: write_en high %0d consecutive clocks, required 1", 2);
      end
      checks++;
      if (!bv_prev) begin
        errors++;
        $display("FAIL write_latency: byte_valid one clock before write_en was %b, required 1", bv_prev);
      end
    end
    we_prev <= bus_if.write_en;
    bv_prev <= dut.u_rx.byte_valid;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  // Reference model: write i goes to (base + i) mod 2^16, and the load is good
  // when the arithmetic sum of all data bytes plus the checksum is a multiple of 256.
  task automatic run_load(input string name, input logic [15:0] base,
                          input byte_q_t data, input logic [7:0] csum);
    int n;
    int s;
    bit exp_ok;
    logic [26:0] exp_w;
    n = data.size();
    s = 0;
    foreach (data[i]) s += int'(data[i]);
    exp_ok = ((s + int'(csum)) % 256) == 0;
    wq.delete();
    send_byte(CMD_LOAD);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    send_byte(8'(n));
    foreach (data[i]) send_byte(data[i]);
    checks++;
    if (wq.size() != n) begin
      errors++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, wq.size(), n);
    end
    checks++;
    if (bus_if.address !== {3'b000, 16'(int'(base) + n)}) begin
      errors++;
      $display("FAIL %s_final_addr: got %h, required %h", name, bus_if.address, {3'b000, 16'(int'(base) + n)});
    end
    send_byte(csum);
    for (int i = 0; i < n; i++) begin
      if (i < wq.size()) begin
        exp_w = {3'b000, 16'(int'(base) + i), data[i]};
        checks++;
        if (wq[i] !== exp_w) begin
          errors++;
          $display("FAIL %s_write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                   name, i, wq[i][26:8], wq[i][7:0], exp_w[26:8], exp_w[7:0]);
        end
      end
    end
    checks++;
    if (bus_if.load_ok !== exp_ok || bus_if.load_err !== !exp_ok) begin
      errors++;
      $display("FAIL %s_status: got ok=%b err=%b, required ok=%b err=%b",
               name, bus_if.load_ok, bus_if.load_err, exp_ok, !exp_ok);
    end
    checks++;
    if (bus_if.cpu_hold !== 1'b1 || bus_if.write_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold: got cpu_hold=%b write_en=%b, required 1 0", name, bus_if.cpu_hold, bus_if.write_en);
    end
    $display("load %s base=%h len=%0d csum=%h writes=%0d ok=%b err=%b",
             name, base, n, csum, wq.size(), bus_if.load_ok, bus_if.load_err);
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus_if.address !== 19'h0 || bus_if.write_en !== 1'b0 || bus_if.data_out !== 8'h00 ||
        bus_if.load_ok !== 1'b0 || bus_if.load_err !== 1'b0 || bus_if.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s: got addr=%h we=%b data=%h ok=%b err=%b hold=%b, required 0 0 0 0 0 1",
               name, bus_if.address, bus_if.write_en, bus_if.data_out,
               bus_if.load_ok, bus_if.load_err, bus_if.cpu_hold);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check_reset_values("post_reset_idle");
    $display("reset done");
  endtask

  task automatic test_good_load();
    byte_q_t d;
    d = '{8'h11, 8'h22, 8'h33};
    run_load("good", 16'hFF00, d, 8'h9A);
  endtask

  task automatic test_bad_csum();
    byte_q_t d;
    d = '{8'h11, 8'h22, 8'h33};
    run_load("bad_csum", 16'hFF00, d, 8'h00);
  endtask

  task automatic test_wrap();
    byte_q_t d;
    d = '{8'hAA, 8'hBB};
    run_load("wrap", 16'hFFFF, d, 8'h9B);
  endtask

  task automatic test_len256();
    byte_q_t d;
    int s;
    s = 0;
    for (int i = 0; i < 256; i++) begin
      d.push_back(8'($urandom));
      s += int'(d[i]);
    end
    run_load("len256", 16'h0000, d, 8'((256 - (s % 256)) % 256));
  endtask

  task automatic test_hold();
    logic ok_before, err_before;
    send_byte(CMD_GO);
    checks++;
    if (bus_if.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL go_release: cpu_hold=%b, required 0", bus_if.cpu_hold);
    end
    $display("cmd G cpu_hold=%b", bus_if.cpu_hold);
    ok_before = bus_if.load_ok;
    err_before = bus_if.load_err;
    wq.delete();
    send_byte(8'h5A);  // 'Z'
    checks++;
    if (bus_if.cpu_hold !== 1'b0 || bus_if.load_ok !== ok_before ||
        bus_if.load_err !== err_before || wq.size() != 0) begin
      errors++;
      $display("FAIL idle_ignore: hold=%b ok=%b err=%b writes=%0d, required 0 %b %b 0",
               bus_if.cpu_hold, bus_if.load_ok, bus_if.load_err, wq.size(), ok_before, err_before);
    end
    $display("cmd Z cpu_hold=%b", bus_if.cpu_hold);
    send_byte(CMD_LOAD);
    checks++;
    if (bus_if.cpu_hold !== 1'b1 || bus_if.load_ok !== 1'b0 || bus_if.load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_accept: hold=%b ok=%b err=%b, required 1 0 0",
               bus_if.cpu_hold, bus_if.load_ok, bus_if.load_err);
    end
    $display("cmd L cpu_hold=%b", bus_if.cpu_hold);
    // Finish this load with a 'G' as the data byte: it must be written, not obeyed.
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h01);
    send_byte(CMD_GO);
    send_byte(8'hB9);
    checks++;
    if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== {19'h00040, CMD_GO}) ||
        bus_if.cpu_hold !== 1'b1 || bus_if.load_ok !== 1'b1) begin
      errors++;
      $display("FAIL g_as_data: writes=%0d hold=%b ok=%b, required 1 write of 47@00040 hold=1 ok=1",
               wq.size(), bus_if.cpu_hold, bus_if.load_ok);
    end
    $display("load g_as_data writes=%0d hold=%b ok=%b", wq.size(), bus_if.cpu_hold, bus_if.load_ok);
  endtask

  task automatic test_frame_err();
    wq.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h02);
    send_byte(8'hAB);
    send_frame(8'h55, 1'b0);
    checks++;
    if (bus_if.load_err !== 1'b1 || bus_if.load_ok !== 1'b0 || bus_if.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL frame_abort: ok=%b err=%b hold=%b, required 0 1 1",
               bus_if.load_ok, bus_if.load_err, bus_if.cpu_hold);
    end
    checks++;
    if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== {19'h01234, 8'hAB})) begin
      errors++;
      $display("FAIL frame_writes: got %0d writes, required 1 write of AB@01234", wq.size());
    end
    // Back in IDLE, so 'G' must be obeyed.
    send_byte(CMD_GO);
    checks++;
    if (bus_if.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL frame_then_idle: cpu_hold=%b, required 0", bus_if.cpu_hold);
    end
    $display("load frame_err writes=%0d err=%b hold_after_G=%b", wq.size(), bus_if.load_err, bus_if.cpu_hold);
  endtask

  task automatic test_frame_err_idle();
    byte_q_t d;
    d = '{8'h01, 8'h02};
    run_load("pre_idle_ferr", 16'h0300, d, 8'hFD);
    send_byte(CMD_GO);
    send_frame(8'h00, 1'b0);
    checks++;
    if (bus_if.load_err !== 1'b0 || bus_if.load_ok !== 1'b1 || bus_if.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL idle_frame_err: ok=%b err=%b hold=%b, required 1 0 0",
               bus_if.load_ok, bus_if.load_err, bus_if.cpu_hold);
    end
    $display("idle frame_err ok=%b err=%b hold=%b", bus_if.load_ok, bus_if.load_err, bus_if.cpu_hold);
  endtask

  task automatic test_reset_midload();
    byte_q_t d;
    int s;
    wq.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h5A);
    // Partial second data byte: start bit and three data bits.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(i);
      repeat (CPB) @(negedge clk);
    end
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check_reset_values("midload_in_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check_reset_values("midload_after_reset");
    checks++;
    if (wq.size() != 1) begin
      errors++;
      $display("FAIL midload_writes: got %0d writes, required 1", wq.size());
    end
    $display("reset mid-load writes=%0d", wq.size());
    s = 0;
    for (int i = 0; i < 3; i++) begin
      d.push_back(8'($urandom));
      s += int'(d[i]);
    end
    run_load("after_reset", 16'h2000, d, 8'((256 - (s % 256)) % 256));
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      byte_q_t d;
      int n;
      int s;
      logic [7:0] cs;
      logic [15:0] base;
      base = 16'($urandom);
      n = int'($urandom_range(1, 6));
      s = 0;
      for (int i = 0; i < n; i++) begin
        d.push_back(8'($urandom));
        s += int'(d[i]);
      end
      if ($urandom_range(0, 1) == 1) cs = 8'((256 - (s % 256)) % 256);
      else cs = 8'($urandom);
      run_load("random", base, d, cs);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_hold();
    test_wrap();
    test_len256();
    test_frame_err();
    test_frame_err_idle();
    test_reset_midload();
    test_random();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
